// File: rtl/dd_pkg.sv
// Shared types and constants for the dark-mode apply path.
// Optional cross-fade is selected with the DD_FADE_EN macro.
package dd_pkg;

    localparam int PIX_W      = 8;
    localparam int RGB_W      = 24;
    localparam int DEF_HOLD   = 3;
    localparam int DEF_FADE_W = 4;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        TO_DARK   = 2'd1,
        DARK      = 2'd2,
        TO_NORMAL = 2'd3
    } apply_state_t;

endpackage

// File: rtl/chan_blend.sv
// One 8-bit colour channel: blends the pixel with its inverse by alpha.
// Two register stages; alpha is captured together with the pixel in stage 1.
// DD_FADE_EN defined: weighted cross-fade. Undefined: plain inversion,
// where any non-zero alpha (only ever 0 or M) means "inverted".
module chan_blend
    import dd_pkg::*;
#(
    parameter int FADE_W = DEF_FADE_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [PIX_W-1:0]  c_i,
    input  logic [FADE_W:0]   alpha_i,
    output logic [PIX_W-1:0]  c_o
);

`ifdef DD_FADE_EN
    localparam int              P_W = PIX_W + FADE_W + 1;
    localparam logic [FADE_W:0] M   = {1'b1, {FADE_W{1'b0}}};

    logic [P_W-1:0]   w_p;
    logic [P_W-1:0]   r_p;
    logic [P_W-1:0]   w_q;
    logic [PIX_W-1:0] r_c;

    // c*(M-alpha) + (255-c)*alpha; the sum never exceeds 255*M
    assign w_p = P_W'(c_i) * P_W'(M - alpha_i)
               + P_W'({PIX_W{1'b1}} - c_i) * P_W'(alpha_i);
    assign w_q = r_p >> FADE_W;

    // Stage 1: weighted sum of pixel and its inverse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_p <= '0;
        else         r_p <= w_p;
    end

    // Stage 2: scale back to 8 bits; the clamp is unreachable but keeps the byte view total
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                r_c <= '0;
        else if (|w_q[P_W-1:PIX_W]) r_c <= '1;
        else                        r_c <= w_q[PIX_W-1:0];
    end
`else
    logic             w_inv;
    logic [PIX_W-1:0] r_x;
    logic [PIX_W-1:0] r_c;

    assign w_inv = |alpha_i;

    // Stage 1: invert the channel when dark mode is committed
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_x <= '0;
        else         r_x <= c_i ^ {PIX_W{w_inv}};
    end

    // Stage 2: plain delay so latency matches the fade build
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_c <= '0;
        else         r_c <= r_x;
    end
`endif

    assign c_o = r_c;

endmodule

// File: rtl/lin_apply.sv
// Applies the line analyser's dark/bright decision to the RGB stream.
// Frame-tick detection, hysteresis and the fade FSM live here; the
// per-channel arithmetic is in chan_blend. Sync/DE get a 2-cycle delay.
// DD_FADE_EN defined: timed cross-fade. Undefined: hard switch at the tick.
module lin_apply
    import dd_pkg::*;
#(
    parameter int HOLD   = DEF_HOLD,
    parameter int FADE_W = DEF_FADE_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              vs_i,
    input  logic              hs_i,
    input  logic              de_i,
    input  logic [RGB_W-1:0]  data_i,
    input  logic              dark_i,
    output logic              vs_o,
    output logic              hs_o,
    output logic              de_o,
    output logic [RGB_W-1:0]  data_o,
    output logic [FADE_W:0]   alpha_o
);

    localparam int                  ALPHA_W  = FADE_W + 1;
    localparam logic [ALPHA_W-1:0]  M        = {1'b1, {FADE_W{1'b0}}};
    localparam int                  CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(HOLD - 1);

    logic r_vs1, r_hs1, r_de1;
    logic r_vs2, r_hs2, r_de2;

    logic               r_target;
    logic               w_target_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    apply_state_t       r_state;
    apply_state_t       w_state_nxt;
    logic [ALPHA_W-1:0] r_alpha;
    logic [ALPHA_W-1:0] w_alpha_nxt;
    logic               w_tick;

    logic [PIX_W-1:0]   w_r, w_g, w_b;

    // Sync/DE delay line matching the two pixel stages
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vs1 <= 1'b0; r_hs1 <= 1'b0; r_de1 <= 1'b0;
            r_vs2 <= 1'b0; r_hs2 <= 1'b0; r_de2 <= 1'b0;
        end else begin
            r_vs1 <= vs_i;  r_hs1 <= hs_i;  r_de1 <= de_i;
            r_vs2 <= r_vs1; r_hs2 <= r_hs1; r_de2 <= r_de1;
        end
    end

    // The first delay stage doubles as the edge detector for the frame tick
    assign w_tick = vs_i & ~r_vs1;

    // Hysteresis: retarget only on the HOLD-th consecutive differing tick
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        if (w_tick) begin
            if (dark_i != r_target) begin
                if (r_cnt == CNT_LAST) begin
                    w_target_nxt = dark_i;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end else begin
                w_cnt_nxt = '0;
            end
        end
    end

`ifdef DD_FADE_EN
    apply_state_t w_state_mid;

    // Fade FSM: direction follows the new target, then alpha steps once
    always_comb begin
        w_state_mid = r_state;
        w_state_nxt = r_state;
        w_alpha_nxt = r_alpha;
        if (w_tick) begin
            case (r_state)
                NORMAL, TO_NORMAL: if (w_target_nxt)  w_state_mid = TO_DARK;
                DARK, TO_DARK:     if (!w_target_nxt) w_state_mid = TO_NORMAL;
                default:           w_state_mid = NORMAL;
            endcase
            w_state_nxt = w_state_mid;
            case (w_state_mid)
                TO_DARK: begin
                    w_alpha_nxt = (r_alpha >= M) ? M : r_alpha + ALPHA_W'(1);
                    if (w_alpha_nxt == M) w_state_nxt = DARK;
                end
                TO_NORMAL: begin
                    w_alpha_nxt = (r_alpha == '0) ? '0 : r_alpha - ALPHA_W'(1);
                    if (w_alpha_nxt == '0) w_state_nxt = NORMAL;
                end
                DARK:    w_alpha_nxt = M;
                default: w_alpha_nxt = '0;
            endcase
        end
    end
`else
    // Hard switch: the committed target selects full or no inversion at the tick
    always_comb begin
        w_state_nxt = r_state;
        w_alpha_nxt = r_alpha;
        if (w_tick) begin
            w_state_nxt = w_target_nxt ? DARK : NORMAL;
            w_alpha_nxt = w_target_nxt ? M : '0;
        end
    end
`endif

    // Decision state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_target <= 1'b0;
            r_cnt    <= '0;
            r_state  <= NORMAL;
            r_alpha  <= '0;
        end else begin
            r_target <= w_target_nxt;
            r_cnt    <= w_cnt_nxt;
            r_state  <= w_state_nxt;
            r_alpha  <= w_alpha_nxt;
        end
    end

    chan_blend #(.FADE_W(FADE_W)) u_blend_r (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .c_i     (data_i[23:16]),
        .alpha_i (r_alpha),
        .c_o     (w_r)
    );

    chan_blend #(.FADE_W(FADE_W)) u_blend_g (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .c_i     (data_i[15:8]),
        .alpha_i (r_alpha),
        .c_o     (w_g)
    );

    chan_blend #(.FADE_W(FADE_W)) u_blend_b (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .c_i     (data_i[7:0]),
        .alpha_i (r_alpha),
        .c_o     (w_b)
    );

    assign vs_o    = r_vs2;
    assign hs_o    = r_hs2;
    assign de_o    = r_de2;
    assign data_o  = r_de2 ? {w_r, w_g, w_b} : '0;
    assign alpha_o = r_alpha;

endmodule
